// File: rtl/iob_split_guard.sv
// iob_split_guard: routes one native-bus master to N_SLAVES slaves by an address field.
// Unmapped indices are answered with an error response; slaves that stall past TIMEOUT
// cycles are aborted. Each error completion is logged (count, last address, cause).
module iob_split_guard #(
    parameter int unsigned       N_SLAVES  = 2,
    parameter int unsigned       SEL_W     = 2,
    parameter int unsigned       SEL_LSB   = 28,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       TIMEOUT   = 1023,
    parameter int unsigned       TMR_W     = 10,
    parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEADBEEF,
    parameter int unsigned       ERR_CNT_W = 8,
    localparam int unsigned      REQ_W     = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int unsigned      RESP_W    = DATA_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       err,
    output logic                       err_type,
    output logic [ADDR_W-1:0]          err_addr,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    localparam logic [SEL_W:0]     N_MAP     = (SEL_W + 1)'(N_SLAVES);
    localparam logic [TMR_W-1:0]   TMR_LIMIT = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);

    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

    state_e              state_q;
    logic [SEL_W-1:0]    sel_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [ADDR_W-1:0]   addr_q;

    logic                m_valid;
    logic [ADDR_W-1:0]   m_addr;
    logic [SEL_W-1:0]    m_idx;
    logic                m_mapped;
    logic [SEL_W-1:0]    route_sel;
    logic                route_en;
    logic [RESP_W-1:0]   sel_resp;
    logic                sel_ready;
    logic                timeout_hit;
    logic                abort;
    logic                complete;

    assign m_valid  = m_req[REQ_W-1];
    assign m_addr   = m_req[REQ_W-2 -: ADDR_W];
    assign m_idx    = m_addr[SEL_LSB +: SEL_W];
    assign m_mapped = {1'b0, m_idx} < N_MAP;

    // Pick the routed slave and its response; in IDLE decode directly for zero latency.
    always_comb begin
        route_sel = (state_q == StIdle) ? m_idx : sel_q;
        sel_resp  = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            if (route_sel == k[SEL_W-1:0]) begin
                sel_resp = s_resp[k*RESP_W +: RESP_W];
            end
        end
    end

    // Routing enable, timeout abort and the error pulse; reset masks everything visible.
    always_comb begin
        sel_ready   = sel_resp[0];
        timeout_hit = (TIMEOUT != 0) && (tmr_q == TMR_LIMIT);
        // A slave ready in the timeout cycle wins over the abort.
        abort       = (state_q == StBusy) && timeout_hit && !sel_ready;
        route_en    = 1'b0;
        unique case (state_q)
            StIdle:  route_en = m_valid && m_mapped;
            StBusy:  route_en = !abort;
            default: route_en = 1'b0;
        endcase
        if (rst) begin
            route_en = 1'b0;
        end
        complete = route_en && m_valid && sel_ready;
        err      = !rst && ((state_q == StErr) || abort);
    end

    // Fan the request out to every slave, asserting valid only on the routed one.
    always_comb begin
        s_req = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            s_req[k*REQ_W +: REQ_W] = {m_valid && route_en && (route_sel == k[SEL_W-1:0]),
                                       m_req[REQ_W-2:0]};
        end
    end

    // Master response: slave data on normal completion, ERR_DATA on error, else all zero.
    always_comb begin
        m_resp = '0;
        if (complete) begin
            m_resp = {sel_resp[RESP_W-1:1], 1'b1};
        end else if (err) begin
            m_resp = {ERR_DATA, 1'b1};
        end
    end

    // Control FSM, timeout timer and error log.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            tmr_q    <= '0;
            addr_q   <= '0;
            err_type <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m_valid) begin
                        if (m_mapped) begin
                            sel_q <= m_idx;
                            if (!sel_ready) begin
                                state_q <= StBusy;
                                tmr_q   <= TMR_ONE;
                            end
                        end else begin
                            addr_q  <= m_addr;
                            state_q <= StErr;
                        end
                    end
                end
                StBusy: begin
                    tmr_q <= tmr_q + TMR_ONE;
                    if (sel_ready || abort) begin
                        state_q <= StIdle;
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            if (err) begin
                err_type <= (state_q == StBusy);
                err_addr <= (state_q == StErr) ? addr_q : m_addr;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_split_guard.sv
// Scoreboard bench for iob_split_guard: stimulus pushes expected completions, a negedge
// monitor pops and compares them and tracks the expected error log.
module tb_iob_split_guard;

    localparam int NS     = 3;
    localparam int TO     = 16;
    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [REQ_W-1:0]       m_req = '0;
    logic [RESP_W-1:0]      m_resp;
    logic [NS*REQ_W-1:0]    s_req;
    logic [NS*RESP_W-1:0]   s_resp = '0;
    logic                   err;
    logic                   err_type;
    logic [31:0]            err_addr;
    logic [7:0]             err_cnt;

    iob_split_guard #(
        .N_SLAVES (3),
        .SEL_W    (2),
        .SEL_LSB  (28),
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT  (16),
        .TMR_W    (10),
        .ERR_DATA (32'hDEADBEEF),
        .ERR_CNT_W(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_resp  (m_resp),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .err     (err),
        .err_type(err_type),
        .err_addr(err_addr),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        etype;
        logic [31:0] addr;
        int          issue;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Expected error log, as of completions before the current cycle.
    int          mdl_cnt  = 0;
    logic        mdl_type = 1'b0;
    logic [31:0] mdl_addr = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: log registers every cycle, completions against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            mdl_cnt  = 0;
            mdl_type = 1'b0;
            mdl_addr = '0;
            check("rst_m_ready", m_resp[0], 1'b0);
            check("rst_s_valid", {s_req[3*REQ_W-1], s_req[2*REQ_W-1], s_req[REQ_W-1]}, 3'b000);
            check("rst_err", err, 1'b0);
        end else begin
            check("log_cnt", err_cnt, mdl_cnt[7:0]);
            check("log_addr", err_addr, mdl_addr);
            check("log_type", err_type, mdl_type);
            if (m_resp[0]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", m_resp[0], 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rdata", m_resp[32:1], mon_e.rdata);
                    check("err_pulse", err, mon_e.err);
                    check("latency", cyc - mon_e.issue, mon_e.lat);
                    if (mon_e.err) begin
                        if (mdl_cnt < 255) mdl_cnt++;
                        mdl_type = mon_e.etype;
                        mdl_addr = mon_e.addr;
                    end
                end
            end else begin
                check("idle_resp", {err, m_resp}, '0);
            end
        end
    end

    task automatic junk_resp();
        for (int k = 0; k < NS; k++) begin
            s_resp[k*RESP_W +: RESP_W] = {32'($urandom), 1'($urandom_range(1))};
        end
    endtask

    // One master transaction; the addressed slave raises ready in cycle lat (lat > TO: never).
    // Called and returns at posedge+1.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int lat, input logic [31:0] rd);
        int   idx;
        bit   mapped;
        exp_t e;
        int   c;
        bit   done;
        bit   exp_v;
        idx    = int'(addr[29:28]);
        mapped = idx < NS;
        e.addr  = addr;
        e.issue = cyc;
        if (!mapped) begin
            e.rdata = 32'hDEADBEEF; e.err = 1'b1; e.etype = 1'b0; e.lat = 1;
        end else if (lat <= TO) begin
            e.rdata = rd;           e.err = 1'b0; e.etype = 1'b0; e.lat = lat;
        end else begin
            e.rdata = 32'hDEADBEEF; e.err = 1'b1; e.etype = 1'b1; e.lat = TO;
        end
        exp_q.push_back(e);
        m_req = {1'b1, addr, wd, ws};
        junk_resp();
        if (mapped) s_resp[idx*RESP_W +: RESP_W] = {rd, lat == 0};
        c    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            for (int k = 0; k < NS; k++) begin
                exp_v = mapped && (k == idx) && !(lat > TO && c == TO);
                check("s_valid", s_req[k*REQ_W+REQ_W-1], exp_v);
                if (exp_v) check("s_payload", s_req[k*REQ_W +: REQ_W-1], m_req[REQ_W-2:0]);
            end
            if (m_resp[0]) begin
                done = 1'b1;
            end else if (c >= 40) begin
                check("ready_bound", m_resp[0], 1'b1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            c++;
            if (!done && mapped) s_resp[idx*RESP_W] = (c == lat);
        end
        m_req = '0;
        junk_resp();
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_err_cnt", err_cnt, 8'd0);
        check("reset_err_addr", err_addr, 32'd0);
        check("reset_err_type", err_type, 1'b0);
        check("reset_m_resp", {err, m_resp}, '0);
        @(posedge clk);
        #1;

        // Read to slave 1, ready after 3 cycles.
        do_txn(32'h1000_0004, 32'h0, 4'b0000, 3, 32'h1234_5678);
        // Zero-latency write to slave 0.
        do_txn(32'h0000_0010, 32'hCAFE_F00D, 4'b0011, 0, 32'h0BAD_0BAD);
        // Unmapped index 3.
        do_txn(32'h3000_0000, 32'h0, 4'b0000, 0, 32'h0);
        check("unmapped_type", err_type, 1'b0);
        check("unmapped_addr", err_addr, 32'h3000_0000);
        check("unmapped_cnt", err_cnt, 8'd1);
        // Slave 2 never ready, then ready exactly in the timeout cycle.
        do_txn(32'h2000_0100, 32'h0, 4'b0000, 20, 32'h5555_AAAA);
        check("timeout_type", err_type, 1'b1);
        check("timeout_addr", err_addr, 32'h2000_0100);
        check("timeout_cnt", err_cnt, 8'd2);
        do_txn(32'h2000_0104, 32'h0, 4'b0000, 16, 32'h7777_1111);
        check("edge_ready_cnt", err_cnt, 8'd2);
        // Back-to-back completions with no gap.
        do_txn(32'h0000_0020, 32'h1, 4'b1111, 0, 32'hA1);
        do_txn(32'h1000_0020, 32'h2, 4'b0001, 0, 32'hA2);

        // Counter saturation.
        repeat (300) do_txn(32'h3000_0000 | ($urandom & 32'h0FFF_FFFF), $urandom, 4'($urandom),
                            0, 32'h0);
        check("sat_cnt", err_cnt, 8'd255);

        // Reset while a slave transaction is outstanding.
        m_req  = {1'b1, 32'h2000_0008, 32'h0, 4'b0000};
        s_resp = '0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("busy_rst_s2_valid", s_req[3*REQ_W-1], 1'b0);
        check("busy_rst_m_ready", m_resp[0], 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        m_req = '0;
        rst   = 1'b0;
        @(negedge clk);
        check("post_rst_cnt", err_cnt, 8'd0);
        check("post_rst_type", err_type, 1'b0);
        @(posedge clk);
        #1;
        do_txn(32'h2000_0040, 32'h0, 4'b0000, 2, 32'h600D_D00D);

        // Randomised traffic.
        repeat (200) begin
            do_txn($urandom, $urandom, 4'($urandom), int'($urandom_range(20)), $urandom);
            repeat ($urandom_range(1)) begin
                @(posedge clk);
                #1;
            end
        end

        @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
